monitor_ventana: RTL and testbench
==================================

# monitor_ventana

Windowed statistics stage placed directly downstream of the feedback accumulator. It consumes the accumulator's 6-bit registered sum and overflow flag. Over each window of 2^LOG2_WIN accepted samples it computes min, max, sum, truncated mean and overflow count. It presents each result with a valid/ready handshake to the debug/VIO/ILA side.

## Interface
- NB_DATA, 6, width of the input sample (matches the accumulator output width)
- LOG2_WIN, 3, log2 of window length; window = 2^LOG2_WIN samples (default 8)
- NB_SUM, NB_DATA+LOG2_WIN, width of the window sum (derived; must not be overridden)

Ports:
- clock  input  1  single clock; all state updates on the rising edge
- i_rst  input  1  synchronous, active-high reset
- i_valid  input  1  sample strobe; sample accepted on any edge where i_valid=1 and the block is not holding a result (see Operation)
- i_data  input  NB_DATA  unsigned sample from the accumulator
- i_overflow  input  1  accumulator overflow flag, qualified by i_valid
- i_ready  input  1  consumer accepts the current result
- o_valid  output  1  result registers hold a complete window
- o_min  output  NB_DATA  minimum sample of the window
- o_max  output  NB_DATA  maximum sample of the window
- o_sum  output  NB_SUM  exact sum of the window
- o_mean  output  NB_DATA  o_sum >> LOG2_WIN (truncated)
- o_ovf_count  output  LOG2_WIN+1  number of samples with i_overflow=1 in the window
- o_drop  output  1  one-cycle pulse: a valid sample was discarded because a result was held

## Operation
- States: ACCUM (collecting samples) and HOLD (result presented, o_valid=1).
- ACCUM:
  - On each edge with i_valid=1, the sample is accepted.
  - The sample counter increments.
  - The running sum adds i_data zero-extended to NB_SUM bits.
  - The overflow counter adds i_overflow.
  - Running min/max are updated.
  - The first sample of a window loads min and max directly; the previous window's values are never compared.
- Window completion:
  - The edge that accepts sample number 2^LOG2_WIN (counter = 2^LOG2_WIN−1) loads the output registers with results that include that sample.
  - The same edge clears the running state and the counter, and moves to HOLD.
- HOLD:
  - Outputs are stable while o_valid=1 and i_ready=0.
  - Any i_valid=1 in HOLD with i_ready=0 is discarded. o_drop=1 on the following cycle, for one cycle per discarded sample.
  - An edge with i_ready=1 returns to ACCUM and o_valid goes to 0.
  - If i_valid=1 on that same edge, the sample is accepted as sample 1 of the next window. It is not dropped and o_drop stays 0.
- Gaps: cycles with i_valid=0 change nothing. Windows count accepted samples, not cycles.
- Arithmetic:
  - The sum never wraps, because NB_SUM covers 2^LOG2_WIN × (2^NB_DATA−1).
  - o_ovf_count never wraps; its maximum is 2^LOG2_WIN.
  - Mean is floor division.
- Output registers (o_min/o_max/o_sum/o_mean/o_ovf_count) keep their last values after the handshake until the next window completes.

## Timing
- Reset values: o_valid=0, o_min=0, o_max=0, o_sum=0, o_mean=0, o_ovf_count=0, o_drop=0. State ACCUM, counter 0, running sum/min/max/ovf count cleared.
- Reset is sampled only on the clock edge and has priority over every other input on that edge.
- Reset mid-window discards the partial window; the next window needs 2^LOG2_WIN fresh samples.
- Reset while o_valid=1 clears o_valid on that edge; the held result is lost.
- Latency: last sample on edge N → o_valid=1 and results valid after edge N, i.e. during cycle N+1.
- Throughput: one window every 2^LOG2_WIN cycles when i_valid=1 continuously and i_ready=1. There are no dead cycles; the handshake-edge sample is accepted.
- With i_ready held high, o_valid is high for exactly one cycle per window.
- o_drop is registered and asserted in the cycle after the discarded-sample edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert i_rst for 2 cycles with random i_valid/i_data → all outputs 0. After release, 8 samples are needed for the first o_valid.
- Basic window: i_ready=1, i_data=1..8 on 8 consecutive cycles, i_overflow=0 → one cycle later o_valid=1 for exactly 1 cycle, o_sum=36, o_mean=4, o_min=1, o_max=8, o_ovf_count=0.
- Full scale: 8 samples of 63 with i_overflow=1 → o_sum=504, o_mean=63, o_min=o_max=63, o_ovf_count=8 (no wrap).
- Backpressure:
  - Complete a window with data 5,9,2,7,7,1,3,6, then hold i_ready=0 for 5 cycles while driving 3 valid samples → outputs stable (o_sum=40, o_mean=5, o_min=1, o_max=9); o_drop pulses 3 times.
  - Then i_ready=1 with i_valid=1, i_data=10 on the same edge → o_valid falls and 10 becomes sample 1 of the next window. Seven more samples of 10 → o_min=o_max=10, o_sum=80.
- Gapped input: 8 samples spread over 20 cycles with random i_valid gaps → a single o_valid one cycle after the 8th accepted sample, with correct statistics.
- Reset mid-window: 5 samples of 20, i_rst for 1 cycle, then 8 samples of 4 → o_sum=32, o_min=4, o_max=4, o_mean=4; no stale contribution from the 20s.

Source files
------------

// File: rtl/monitor_ventana.sv
// monitor_ventana: windowed min/max/sum/mean/overflow-count over 2^LOG2_WIN
// accepted samples, with the result held under a valid/ready handshake.
// Ports: clock, i_rst (sync, active-high)
//        i_valid/i_data/i_overflow : sample stream from the accumulator
//        i_ready                   : consumer takes the held result
//        o_valid/o_min/o_max/o_sum/o_mean/o_ovf_count : registered result
//        o_drop                    : one-cycle pulse per discarded sample
module monitor_ventana #(
  parameter int NB_DATA  = 6,
  parameter int LOG2_WIN = 3,
  parameter int NB_SUM   = NB_DATA + LOG2_WIN
) (
  input  logic                clock,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic [NB_DATA-1:0]  i_data,
  input  logic                i_overflow,
  input  logic                i_ready,
  output logic                o_valid,
  output logic [NB_DATA-1:0]  o_min,
  output logic [NB_DATA-1:0]  o_max,
  output logic [NB_SUM-1:0]   o_sum,
  output logic [NB_DATA-1:0]  o_mean,
  output logic [LOG2_WIN:0]   o_ovf_count,
  output logic                o_drop
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [LOG2_WIN-1:0] CNT_ONE = 1;

  state_t state_q, state_d;

  logic [LOG2_WIN-1:0] cnt_q, cnt_d;
  logic [NB_SUM-1:0]   sum_q, sum_d;
  logic [NB_DATA-1:0]  min_q, min_d;
  logic [NB_DATA-1:0]  max_q, max_d;
  logic [LOG2_WIN:0]   ovf_q, ovf_d;

  logic [NB_DATA-1:0]  omin_q, omin_d;
  logic [NB_DATA-1:0]  omax_q, omax_d;
  logic [NB_SUM-1:0]   osum_q, osum_d;
  logic [NB_DATA-1:0]  omean_q, omean_d;
  logic [LOG2_WIN:0]   oovf_q, oovf_d;
  logic                drop_q, drop_d;

  logic                hold;
  logic                accept;
  logic                first;
  logic                last;
  logic [NB_SUM-1:0]   acc_sum;
  logic [NB_DATA-1:0]  acc_min;
  logic [NB_DATA-1:0]  acc_max;
  logic [LOG2_WIN:0]   acc_ovf;

  always_comb begin
    hold    = (state_q == HOLD);
    // The handshake edge frees the result, so its sample is taken too.
    accept  = i_valid & (~hold | i_ready);
    first   = (cnt_q == '0);
    last    = (cnt_q == '1);
    acc_sum = sum_q + NB_SUM'(i_data);
    // First sample of a window ignores whatever min/max held before.
    acc_min = (first || i_data < min_q) ? i_data : min_q;
    acc_max = (first || i_data > max_q) ? i_data : max_q;
    acc_ovf = ovf_q + (LOG2_WIN+1)'(i_overflow);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    min_d   = min_q;
    max_d   = max_q;
    ovf_d   = ovf_q;
    omin_d  = omin_q;
    omax_d  = omax_q;
    osum_d  = osum_q;
    omean_d = omean_q;
    oovf_d  = oovf_q;
    drop_d  = i_valid & hold & ~i_ready;

    unique case (state_q)
      ACCUM: ;
      HOLD:  if (i_ready) state_d = ACCUM;
    endcase

    if (accept) begin
      if (last) begin
        omin_d  = acc_min;
        omax_d  = acc_max;
        osum_d  = acc_sum;
        omean_d = acc_sum[NB_SUM-1:LOG2_WIN];
        oovf_d  = acc_ovf;
        cnt_d   = '0;
        sum_d   = '0;
        min_d   = '0;
        max_d   = '0;
        ovf_d   = '0;
        state_d = HOLD;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
        sum_d = acc_sum;
        min_d = acc_min;
        max_d = acc_max;
        ovf_d = acc_ovf;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (i_rst) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      sum_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      ovf_q   <= '0;
      omin_q  <= '0;
      omax_q  <= '0;
      osum_q  <= '0;
      omean_q <= '0;
      oovf_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      min_q   <= min_d;
      max_q   <= max_d;
      ovf_q   <= ovf_d;
      omin_q  <= omin_d;
      omax_q  <= omax_d;
      osum_q  <= osum_d;
      omean_q <= omean_d;
      oovf_q  <= oovf_d;
      drop_q  <= drop_d;
    end
  end

  assign o_valid     = (state_q == HOLD);
  assign o_min       = omin_q;
  assign o_max       = omax_q;
  assign o_sum       = osum_q;
  assign o_mean      = omean_q;
  assign o_ovf_count = oovf_q;
  assign o_drop      = drop_q;

endmodule

// File: tb/tb_monitor_ventana.sv
// tb_monitor_ventana: table windows, hand sequences for the corner cases,
// then random traffic against a sample-queue reference model.
module tb_monitor_ventana;

  localparam int NB_DATA  = 6;
  localparam int LOG2_WIN = 3;
  localparam int NB_SUM   = NB_DATA + LOG2_WIN;
  localparam int WIN      = 1 << LOG2_WIN;

  logic               clock = 1'b0;
  logic               i_rst = 1'b1;
  logic               i_valid = 1'b0;
  logic [NB_DATA-1:0] i_data = '0;
  logic               i_overflow = 1'b0;
  logic               i_ready = 1'b0;
  logic               o_valid;
  logic [NB_DATA-1:0] o_min;
  logic [NB_DATA-1:0] o_max;
  logic [NB_SUM-1:0]  o_sum;
  logic [NB_DATA-1:0] o_mean;
  logic [LOG2_WIN:0]  o_ovf_count;
  logic               o_drop;

  monitor_ventana #(.NB_DATA(NB_DATA), .LOG2_WIN(LOG2_WIN)) dut (
    .clock(clock), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .i_overflow(i_overflow), .i_ready(i_ready), .o_valid(o_valid),
    .o_min(o_min), .o_max(o_max), .o_sum(o_sum), .o_mean(o_mean),
    .o_ovf_count(o_ovf_count), .o_drop(o_drop)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the window is a queue of accepted samples.
  int q[$];
  int oq[$];
  bit m_valid = 0;
  bit m_drop = 0;
  int m_min = 0, m_max = 0, m_sum = 0, m_mean = 0, m_ovf = 0;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model(bit rst, bit v, int d, bit ov, bit rdy);
    bit held;
    if (rst) begin
      q.delete(); oq.delete();
      m_valid = 0; m_drop = 0;
      m_min = 0; m_max = 0; m_sum = 0; m_mean = 0; m_ovf = 0;
      return;
    end
    held = m_valid;
    m_drop = v && held && !rdy;
    if (held && rdy) m_valid = 0;
    if (v && (!held || rdy)) begin
      q.push_back(d);
      oq.push_back(int'(ov));
      if (q.size() == WIN) begin
        m_min = q[0]; m_max = q[0]; m_sum = 0; m_ovf = 0;
        foreach (q[k]) begin
          if (q[k] < m_min) m_min = q[k];
          if (q[k] > m_max) m_max = q[k];
          m_sum += q[k];
          m_ovf += oq[k];
        end
        m_mean = m_sum / WIN;
        m_valid = 1;
        q.delete(); oq.delete();
      end
    end
  endtask

  task automatic check_model();
    chk("m_valid", int'(o_valid), int'(m_valid));
    chk("m_min", int'(o_min), m_min);
    chk("m_max", int'(o_max), m_max);
    chk("m_sum", int'(o_sum), m_sum);
    chk("m_mean", int'(o_mean), m_mean);
    chk("m_ovf", int'(o_ovf_count), m_ovf);
    chk("m_drop", int'(o_drop), int'(m_drop));
  endtask

  // Inputs are driven 1 time unit after a rising edge and outputs are
  // sampled 1 time unit after the next one.
  task automatic step(bit rst, bit v, int d, bit ov, bit rdy);
    i_rst = rst; i_valid = v; i_data = NB_DATA'(d);
    i_overflow = ov; i_ready = rdy;
    @(posedge clock);
    model(rst, v, d, ov, rdy);
    #1;
    check_model();
  endtask

  task automatic chk_res(string nm, int s, int mn, int mx, int me, int oc);
    chk({nm, ".valid"}, int'(o_valid), 1);
    chk({nm, ".sum"}, int'(o_sum), s);
    chk({nm, ".min"}, int'(o_min), mn);
    chk({nm, ".max"}, int'(o_max), mx);
    chk({nm, ".mean"}, int'(o_mean), me);
    chk({nm, ".ovf"}, int'(o_ovf_count), oc);
  endtask

  typedef struct {
    logic [7:0][5:0] d;
    logic [7:0]      ov;
    int              sum, mean, mn, mx, oc;
  } win_t;

  win_t tbl[3];

  initial begin
    int acc, drops, s, mn, mx, cyc;
    bit v;

    for (int j = 0; j < 8; j++) begin
      tbl[0].d[j] = 6'(j + 1);
      tbl[1].d[j] = 6'd63;
    end
    tbl[0].ov = 8'h00;
    tbl[0].sum = 36; tbl[0].mean = 4; tbl[0].mn = 1;
    tbl[0].mx = 8; tbl[0].oc = 0;
    tbl[1].ov = 8'hFF;
    tbl[1].sum = 504; tbl[1].mean = 63; tbl[1].mn = 63;
    tbl[1].mx = 63; tbl[1].oc = 8;
    tbl[2].d = {6'd0, 6'd17, 6'd33, 6'd2, 6'd40, 6'd9, 6'd21, 6'd50};
    tbl[2].ov = 8'b1010_0010;
    tbl[2].sum = 172; tbl[2].mean = 21; tbl[2].mn = 0;
    tbl[2].mx = 50; tbl[2].oc = 3;

    // Reset with random traffic on the inputs.
    repeat (2) begin
      step(1, 1'($urandom), $urandom_range(0, 63), 1'($urandom), 1);
      chk("rst.valid", int'(o_valid), 0);
      chk("rst.sum", int'(o_sum), 0);
      chk("rst.min", int'(o_min), 0);
      chk("rst.max", int'(o_max), 0);
      chk("rst.mean", int'(o_mean), 0);
      chk("rst.ovf", int'(o_ovf_count), 0);
      chk("rst.drop", int'(o_drop), 0);
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 1, $urandom_range(0, 63), 1'($urandom), 1);
      chk("first_win.valid", int'(o_valid), (i == 7) ? 1 : 0);
    end
    step(0, 0, 0, 0, 1);

    // Table of complete windows, ready held high.
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 8; i++) begin
        step(0, 1, int'(tbl[t].d[i]), tbl[t].ov[i], 1);
        if (i < 7) chk("tbl.early_valid", int'(o_valid), 0);
      end
      chk_res($sformatf("tbl%0d", t), tbl[t].sum, tbl[t].mn,
              tbl[t].mx, tbl[t].mean, tbl[t].oc);
      step(0, 0, 0, 0, 1);
      chk("tbl.one_cycle", int'(o_valid), 0);
      chk("tbl.keep_sum", int'(o_sum), tbl[t].sum);
    end

    // Backpressure: hold the result, drop three samples.
    begin
      int bp[8] = '{5, 9, 2, 7, 7, 1, 3, 6};
      bit vv[5] = '{1, 0, 1, 1, 0};
      foreach (bp[i]) step(0, 1, bp[i], 0, 1);
      chk_res("bp", 40, 1, 9, 5, 0);
      drops = 0;
      for (int i = 0; i < 5; i++) begin
        step(0, vv[i], 33, 1, 0);
        chk_res("bp.hold", 40, 1, 9, 5, 0);
        chk("bp.drop", int'(o_drop), int'(vv[i]));
        drops += int'(o_drop);
      end
      chk("bp.drop_count", drops, 3);
      step(0, 1, 10, 0, 1);
      chk("bp.release_valid", int'(o_valid), 0);
      chk("bp.release_drop", int'(o_drop), 0);
      repeat (7) step(0, 1, 10, 0, 1);
      chk_res("bp.next", 80, 10, 10, 10, 0);
      step(0, 0, 0, 0, 1);
    end

    // Gapped input: 8 samples spread over 20 cycles.
    acc = 0; s = 0; mn = 99; mx = -1;
    for (cyc = 0; cyc < 20 && acc < 8; cyc++) begin
      v = (20 - cyc <= 8 - acc) ? 1'b1 : 1'($urandom);
      if (v) begin
        int d = $urandom_range(0, 63);
        s += d;
        if (d < mn) mn = d;
        if (d > mx) mx = d;
        acc++;
        step(0, 1, d, 0, 1);
      end else begin
        step(0, 0, $urandom_range(0, 63), 1'($urandom), 1);
      end
      if (acc < 8) chk("gap.early_valid", int'(o_valid), 0);
    end
    chk("gap.accepted", acc, 8);
    chk_res("gap", s, mn, mx, s / 8, 0);
    step(0, 0, 0, 0, 1);

    // Reset mid-window discards the partial window.
    repeat (5) step(0, 1, 20, 1, 1);
    step(1, 1, 20, 1, 1);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 4, 0, 1);
      if (i < 7) chk("midrst.early_valid", int'(o_valid), 0);
    end
    chk_res("midrst", 32, 4, 4, 4, 0);
    step(0, 0, 0, 0, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           $urandom_range(0, 63), 1'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
